// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, with round keys
// fetched by index (10 down to 0) from an external key-expansion store.
module aes_dec_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] cipher_i,
  output logic [3:0]   rnd_idx_o,
  input  logic [127:0] rnd_key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] plain_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  if (NR != 10) begin : g_nr_check
    $error("aes_dec_iter: only NR=10 (AES-128) is supported");
  end

  // Byte n of the block sits at [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = INV_SBOX[s[127-8*n -: 8]];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) as a sum of doublings.
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_cnt_q, rnd_cnt_d;
  logic [127:0] final_out, round_out;

  // The last round is the common prefix of every middle round, minus InvMixColumns.
  assign final_out = inv_sub_bytes(inv_shift_rows(state_q)) ^ rnd_key_i;
  assign round_out = inv_mix_columns(final_out);

  assign in_ready_o  = (fsm_q == IDLE);
  assign out_valid_o = (fsm_q == DONE);
  assign plain_o     = state_q;

  always_comb begin
    rnd_idx_o = 4'(NR);
    case (fsm_q)
      ROUND:       rnd_idx_o = rnd_cnt_q;
      FINAL, DONE: rnd_idx_o = 4'd0;
      default:     ;
    endcase
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_cnt_d = rnd_cnt_q;
    case (fsm_q)
      IDLE: if (in_valid_i) begin
        state_d   = cipher_i ^ rnd_key_i;
        rnd_cnt_d = 4'(NR - 1);
        fsm_d     = ROUND;
      end
      ROUND: begin
        state_d = round_out;
        if (rnd_cnt_q == 4'd1) fsm_d = FINAL;
        else                   rnd_cnt_d = rnd_cnt_q - 4'd1;
      end
      FINAL: begin
        state_d = final_out;
        fsm_d   = DONE;
      end
      DONE: if (out_ready_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_cnt_q <= rnd_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Scoreboard bench for aes_dec_iter: an AES-128 reference model supplies round keys
// by index and expected plaintexts; a monitor checks every output handshake.
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         nrst;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] cipher_i;
  logic [3:0]   rnd_idx_o;
  logic [127:0] rnd_key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] plain_o;

  aes_dec_iter #(.NR(10)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .cipher_i(cipher_i),
    .rnd_idx_o(rnd_idx_o), .rnd_key_i(rnd_key_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .plain_o(plain_o)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] rk [0:10];
  logic [127:0] mk [0:10];
  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int cyc = 0;
  int last_acc = 0;

  assign rnd_key_i = (rnd_idx_o <= 4'd10) ? rk[rnd_idx_o] : '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox_t[s[127-8*n -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic expand_mk(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) mk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ mk[0];
    for (int r = 1; r <= 9; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ mk[r];
    return shift_rows(sub_bytes(s)) ^ mk[10];
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    int w;
    w = 0;
    expand_mk(key);
    @(negedge clk);
    while (in_ready_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready_o=%b expected 1", in_ready_o);
      return;
    end
    for (int i = 0; i <= 10; i++) rk[i] = mk[i];
    cipher_i   = ct;
    in_valid_i = 1'b1;
    exp_q.push_back(pt);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    last_acc   = cyc;
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      out_ready_i = 1'($urandom_range(0, 1));
    else if (ready_mode == 0) out_ready_i = 1'b1;
    else                      out_ready_i = 1'b0;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_output: got %h expected no output", plain_o);
      end else begin
        chk("plaintext", plain_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc0, gap, vcount, w;
    logic [127:0] key, pt;
    nrst = 1'b0; in_valid_i = 1'b0; cipher_i = '0; out_ready_i = 1'b1;
    for (int i = 0; i <= 10; i++) rk[i] = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_plain", plain_o, 128'd0);
    chk("rst_rnd_idx", 128'(rnd_idx_o), 128'd10);
    nrst = 1'b1;

    // C.1 with cycle-by-cycle round index and latency
    send(C1_KEY, C1_CT, C1_PT);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rnd_idx_c%0d", c), 128'(rnd_idx_o), 128'((c < 9) ? 9 - c : 0));
      chk($sformatf("valid_low_c%0d", c), 128'(out_valid_o), 128'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("latency_valid", 128'(out_valid_o), 128'd1);
    chk("done_rnd_idx", 128'(rnd_idx_o), 128'd0);

    // App. B under output backpressure
    ready_mode = 2;
    send(B_KEY, B_CT, B_PT);
    w = 0;
    while (out_valid_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("stall_wait", 128'(out_valid_o), 128'd1);
    for (int c = 0; c < 5; c++) begin
      chk("stall_plain", plain_o, B_PT);
      chk("stall_in_ready", 128'(in_ready_o), 128'd0);
      chk("stall_valid", 128'(out_valid_o), 128'd1);
      @(negedge clk);
    end
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    chk("hs_in_ready", 128'(in_ready_o), 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready", 128'(in_ready_o), 128'd1);
    chk("post_hs_valid", 128'(out_valid_o), 128'd0);

    // busy input ignored, then back-to-back blocks
    send(B_KEY, B_CT, B_PT);
    acc0 = last_acc;
    for (int c = 0; c < 8; c++) begin
      in_valid_i = 1'b1;
      cipher_i   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk("busy_in_ready", 128'(in_ready_o), 128'd0);
    end
    in_valid_i = 1'b0;
    send(C1_KEY, C1_CT, C1_PT);
    gap = last_acc - acc0;
    chk("b2b_gap1", 128'(gap), 128'd12);
    acc0 = last_acc;
    send(B_KEY, B_CT, B_PT);
    gap = last_acc - acc0;
    chk("b2b_gap2", 128'(gap), 128'd12);

    // reset in round 5 aborts silently
    send(C1_KEY, C1_CT, C1_PT);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_round5_idx", 128'(rnd_idx_o), 128'd5);
    nrst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    chk("abort_in_ready", 128'(in_ready_o), 128'd1);
    chk("abort_out_valid", 128'(out_valid_o), 128'd0);
    chk("abort_plain", plain_o, 128'd0);
    chk("abort_rnd_idx", 128'(rnd_idx_o), 128'd10);
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0) vcount++;
    end
    chk("abort_no_output", 128'(vcount), 128'd0);
    send(C1_KEY, C1_CT, C1_PT);

    // random blocks with random output stalls
    ready_mode = 1;
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_mk(key);
      send(key, encrypt(pt), pt);
    end

    ready_mode = 0;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 128'(exp_q.size()), 128'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
